axi_inter_arb_route: RTL and testbench
======================================

// Module: axi_inter_arb_route
// PURPOSE
// - Sequential control for one AXI request/response channel pair (AW/B or AR/R) between 4 masters and 1 slave.
// - Round-robin arbitrates master requests; drives the select of the 4:1 request mux.
// - Records the granted master index per accepted request in an order FIFO.
// - Steers each response back to its originating master via the select of the 1:4 response demux.
// - Sits between the per-master ports and the slave port of the interconnect; datapath muxes live outside.
// PARAMETERS
// - DEPTH    8  max outstanding requests (order FIFO entries); power of 2, >=2
// - CNT_W    4  width of outstanding count = clog2(DEPTH)+1
// PORTS
// - clk            in   1      single clock
// - rst            in   1      asynchronous, active-high reset
// - req_valid      in   4      AxVALID per master
// - req_ready      out  4      AxREADY per master
// - slv_req_valid  out  1      AxVALID to slave
// - slv_req_ready  in   1      AxREADY from slave
// - req_sel        out  2      select for 4:1 request mux
// - slv_rsp_valid  in   1      BVALID/RVALID from slave
// - slv_rsp_last   in   1      RLAST; tie 1 for B channel
// - slv_rsp_ready  out  1      BREADY/RREADY to slave
// - rsp_valid      out  4      BVALID/RVALID per master
// - rsp_ready      in   4      BREADY/RREADY per master
// - rsp_sel        out  2      select for 1:4 response demux (= FIFO head)
// - outstanding    out  CNT_W  entries in order FIFO
// BEHAVIOUR
// - Reset: state=IDLE, req_sel=0, last_grant=3 (so master 0 wins first), FIFO empty, outstanding=0.
// - Reset: all ready/valid outputs 0, rsp_sel=0.
// - FSM IDLE: if |req_valid, pick first set bit searching from last_grant+1 modulo 4.
//   Latch it into req_sel; go to GRANT next cycle. With no request, stay in IDLE.
// - FSM GRANT: slv_req_valid = req_valid[req_sel] & !full; req_ready[req_sel] = slv_req_ready & !full.
//   All other req_ready bits = 0.
// - GRANT handshake (slv_req_valid & slv_req_ready): push req_sel to FIFO, last_grant<=req_sel, go to IDLE.
// - Grant is held in GRANT until handshake; arbitration never changes while a valid is pending (AXI stability).
// - Latency: req_valid rises cycle N (FSM IDLE) -> slv_req_valid earliest cycle N+1.
//   One-cycle IDLE bubble between consecutive grants.
// - Full: slv_req_valid and req_ready forced 0 while outstanding==DEPTH; FSM stays in GRANT.
// - Response path is combinational from FIFO head and port inputs (zero latency).
// - Empty FIFO: slv_rsp_ready=0, rsp_valid=0, rsp_sel=0; an unsolicited slave response is stalled, never routed.
// - Non-empty FIFO: rsp_sel=head; rsp_valid[head]=slv_rsp_valid, other bits 0; slv_rsp_ready=rsp_ready[head].
// - Pop on slv_rsp_valid & slv_rsp_ready & slv_rsp_last; non-last R beats do not pop.
// - Push and pop in the same cycle: head advances, new entry written, outstanding unchanged.
//   When full, no push occurs, so a pop frees one entry for the next cycle.
// - Pointers are log2(DEPTH) bits and wrap naturally; outstanding counts 0..DEPTH.
// - Ordering: the slave returns responses in request order (single-slave, in-order contract).
// - Reset mid-transaction: all state cleared immediately (async); pending requests and responses are dropped.
// STRUCTURE
// - Shared package: state enum {IDLE, GRANT}; master-count constant NMST=4; master index width MIDX_W=2.
// - One sub-module: axi_inter_ord_fifo (DEPTH x 2-bit sync FIFO).
//   It has push/pop/full/empty/head/count and a combinational head read.
// - Arbiter and FSM stay in this module.
// TESTING
// - Single master: req_valid=4'b0100, slv_req_ready=1 -> req_sel=2, slv_req_valid one cycle after request.
//   Expect outstanding=1; rsp with last=1 -> rsp_valid=4'b0100, outstanding=0.
// - All 4 requesting continuously, ready=1 -> grant order 0,1,2,3,0; a new grant every 2 cycles.
// - slv_req_ready=0 for 5 cycles in GRANT, master 1 -> req_sel stays 1.
//   slv_req_valid stays high and no push occurs until ready=1.
// - DEPTH=8 requests with no responses -> outstanding=8, slv_req_valid=0 on 9th request.
//   One response pop then lets the 9th request through; outstanding returns to 8.
// - R burst of 4 beats, last on beat 4 -> rsp_sel is constant for all 4 beats and pops once.
//   Simultaneous push on beat 4 keeps outstanding constant.
// - Empty FIFO with slv_rsp_valid=1 -> slv_rsp_ready=0, rsp_valid=0.
//   Assert rst mid-burst -> all outputs 0 in the same cycle and outstanding=0.

Source files
------------

// File: rtl/axi_inter_arb_route_pkg.sv
// Shared types and helpers for the AXI channel-pair arbiter/router.
package axi_inter_arb_route_pkg;

  localparam int unsigned NMST   = 4;
  localparam int unsigned MIDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef logic [MIDX_W-1:0] midx_t;

  // Round-robin pick: first requester searching upward from last+1, wrapping.
  // Offsets are scanned high to low so the nearest requester is written last.
  function automatic midx_t rr_pick(input logic [NMST-1:0] req, input midx_t last);
    midx_t pick;
    midx_t idx;
    pick = last;
    for (int unsigned i = NMST; i >= 1; i--) begin
      idx = last + midx_t'(i);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/axi_inter_arb_route_if.sv
// Handshake/select bundle between the masters, the slave and the arbiter/router.
interface axi_inter_arb_route_if #(
  parameter int unsigned CNT_W = 4
);
  import axi_inter_arb_route_pkg::*;

  logic [NMST-1:0] req_valid;
  logic [NMST-1:0] req_ready;
  logic            slv_req_valid;
  logic            slv_req_ready;
  midx_t           req_sel;
  logic            slv_rsp_valid;
  logic            slv_rsp_last;
  logic            slv_rsp_ready;
  logic [NMST-1:0] rsp_valid;
  logic [NMST-1:0] rsp_ready;
  midx_t           rsp_sel;
  logic [CNT_W-1:0] outstanding;

  // Environment side: masters and slave driving the arbiter.
  modport master (
    output req_valid, slv_req_ready, slv_rsp_valid, slv_rsp_last, rsp_ready,
    input  req_ready, slv_req_valid, req_sel, slv_rsp_ready, rsp_valid, rsp_sel,
           outstanding
  );

  // Arbiter/router side.
  modport slave (
    input  req_valid, slv_req_ready, slv_rsp_valid, slv_rsp_last, rsp_ready,
    output req_ready, slv_req_valid, req_sel, slv_rsp_ready, rsp_valid, rsp_sel,
           outstanding
  );

endinterface

// File: rtl/axi_inter_ord_fifo.sv
// Order FIFO holding the granted master index of every accepted request.
module axi_inter_ord_fifo
  import axi_inter_arb_route_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  midx_t            wdata,
  input  logic             pop,
  output midx_t            head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  midx_t            mem_q [DEPTH];
  midx_t            mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_inter_arb_route.sv
// Round-robin request arbiter plus in-order response router for one AXI
// channel pair (AW/B or AR/R) between four masters and a single slave.
module axi_inter_arb_route
  import axi_inter_arb_route_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  axi_inter_arb_route_if.slave bus
);

  state_e           state_q, state_d;
  midx_t            req_sel_q, req_sel_d;
  midx_t            last_grant_q, last_grant_d;

  logic             slv_req_valid;
  logic [NMST-1:0]  req_ready;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  midx_t            head;
  logic [CNT_W-1:0] count;

  logic             slv_rsp_ready;
  logic [NMST-1:0]  rsp_valid;
  midx_t            rsp_sel;

  // Grant is held until the slave accepts, so a pending valid never loses its path.
  always_comb begin
    state_d       = state_q;
    req_sel_d     = req_sel_q;
    last_grant_d  = last_grant_q;
    slv_req_valid = 1'b0;
    req_ready     = '0;
    push          = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          req_sel_d = rr_pick(bus.req_valid, last_grant_q);
          state_d   = GRANT;
        end
      end
      GRANT: begin
        slv_req_valid        = bus.req_valid[req_sel_q] & ~full;
        req_ready[req_sel_q] = bus.slv_req_ready & ~full;
        if (slv_req_valid && bus.slv_req_ready) begin
          push         = 1'b1;
          last_grant_d = req_sel_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_sel_q    <= '0;
      last_grant_q <= '1;
    end else begin
      state_q      <= state_d;
      req_sel_q    <= req_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Responses follow the FIFO head; with nothing outstanding the slave is stalled.
  always_comb begin
    slv_rsp_ready = 1'b0;
    rsp_valid     = '0;
    rsp_sel       = '0;
    pop           = 1'b0;
    if (!empty) begin
      rsp_sel         = head;
      rsp_valid[head] = bus.slv_rsp_valid;
      slv_rsp_ready   = bus.rsp_ready[head];
      pop             = bus.slv_rsp_valid & bus.rsp_ready[head] & bus.slv_rsp_last;
    end
  end

  axi_inter_ord_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_ord_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (req_sel_q),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.req_ready     = req_ready;
  assign bus.slv_req_valid = slv_req_valid;
  assign bus.req_sel       = req_sel_q;
  assign bus.slv_rsp_ready = slv_rsp_ready;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_sel       = rsp_sel;
  assign bus.outstanding   = count;

endmodule

// File: tb/tb_axi_inter_arb_route.sv
// Bench for axi_inter_arb_route: arbitration table, directed corner cases and
// a randomized run against a transaction-level queue model.
module tb_axi_inter_arb_route;
  import axi_inter_arb_route_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_inter_arb_route_if #(.CNT_W(CNT_W)) bus ();

  axi_inter_arb_route #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] req;
    int         exp_sel;
  } arb_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid     = '0;
    bus.slv_req_ready = 1'b0;
    bus.slv_rsp_valid = 1'b0;
    bus.slv_rsp_last  = 1'b0;
    bus.rsp_ready     = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},     bus.req_ready, 0);
    chk({tag, "_slv_req_valid"}, bus.slv_req_valid, 0);
    chk({tag, "_req_sel"},       bus.req_sel, 0);
    chk({tag, "_slv_rsp_ready"}, bus.slv_rsp_ready, 0);
    chk({tag, "_rsp_valid"},     bus.rsp_valid, 0);
    chk({tag, "_rsp_sel"},       bus.rsp_sel, 0);
    chk({tag, "_outstanding"},   bus.outstanding, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one request pattern, hold it until the slave accepts, then drop it.
  task automatic do_txn(input logic [3:0] req, output int sel, output int lat);
    bit ok;
    ok  = 1'b0;
    sel = -1;
    lat = -1;
    @(negedge clk);
    bus.req_valid     = req;
    bus.slv_req_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.slv_req_valid === 1'b1) begin
        sel = int'(bus.req_sel);
        lat = c;
        ok  = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("txn_handshake", 32'(ok), 1);
    @(negedge clk);
    bus.req_valid     = '0;
    bus.slv_req_ready = 1'b0;
  endtask

  arb_vec_t tbl [9];

  initial begin
    int sel, lat;
    int gsel [$];
    int gcyc [$];
    int hit;

    rst = 1'b1;
    idle_inputs();

    tbl[0] = '{4'b0100, 2};
    tbl[1] = '{4'b1111, 3};
    tbl[2] = '{4'b1111, 0};
    tbl[3] = '{4'b1001, 3};
    tbl[4] = '{4'b0110, 1};
    tbl[5] = '{4'b0001, 0};
    tbl[6] = '{4'b1000, 3};
    tbl[7] = '{4'b1101, 0};
    tbl[8] = '{4'b0100, 2};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Arbitration table: each entry is a full request/response round trip
    for (int i = 0; i < 9; i++) begin
      do_txn(tbl[i].req, sel, lat);
      chk("tbl_sel", sel, tbl[i].exp_sel);
      chk("tbl_latency", lat, 1);
      #1;
      chk("tbl_outstanding_1", bus.outstanding, 1);
      bus.slv_rsp_valid = 1'b1;
      bus.slv_rsp_last  = 1'b1;
      bus.rsp_ready     = 4'b1111;
      #1;
      chk("tbl_rsp_valid", bus.rsp_valid, 32'(1) << tbl[i].exp_sel);
      chk("tbl_rsp_sel", bus.rsp_sel, tbl[i].exp_sel);
      chk("tbl_slv_rsp_ready", bus.slv_rsp_ready, 1);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("tbl_outstanding_0", bus.outstanding, 0);
    end

    // All four requesting continuously: 0,1,2,3,0 with a grant every 2 cycles
    do_reset();
    bus.req_valid     = 4'b1111;
    bus.slv_req_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.slv_req_valid === 1'b1) begin
        gsel.push_back(int'(bus.req_sel));
        gcyc.push_back(c);
      end
      if (gsel.size() == 5) break;
      @(negedge clk);
    end
    @(negedge clk);
    idle_inputs();
    chk("rr_grant_count", gsel.size(), 5);
    for (int i = 0; i < gsel.size(); i++) chk("rr_order", gsel[i], i % 4);
    for (int i = 1; i < gcyc.size(); i++) chk("rr_spacing", gcyc[i] - gcyc[i-1], 2);
    #1;
    chk("rr_outstanding", bus.outstanding, 5);

    // Slave stalls for 5 cycles in GRANT
    do_reset();
    bus.req_valid = 4'b0010;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_req_sel", bus.req_sel, 1);
      chk("stall_slv_req_valid", bus.slv_req_valid, 1);
      chk("stall_req_ready", bus.req_ready, 0);
      chk("stall_outstanding", bus.outstanding, 0);
      @(negedge clk);
    end
    bus.slv_req_ready = 1'b1;
    #1;
    chk("stall_release_ready", bus.req_ready, 4'b0010);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("stall_outstanding_after", bus.outstanding, 1);

    // Fill to DEPTH; the 9th request waits for a pop
    do_reset();
    bus.req_valid     = 4'b0001;
    bus.slv_req_ready = 1'b1;
    hit = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.outstanding == CNT_W'(DEPTH)) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    chk("full_reached", hit, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("full_slv_req_valid", bus.slv_req_valid, 0);
      chk("full_req_ready", bus.req_ready, 0);
      chk("full_outstanding", bus.outstanding, DEPTH);
    end
    bus.slv_rsp_valid = 1'b1;
    bus.slv_rsp_last  = 1'b1;
    bus.rsp_ready     = 4'b0001;
    #1;
    chk("full_pop_rsp_valid", bus.rsp_valid, 4'b0001);
    @(negedge clk);
    bus.slv_rsp_valid = 1'b0;
    #1;
    chk("full_after_pop_outstanding", bus.outstanding, DEPTH - 1);
    chk("full_ninth_slv_req_valid", bus.slv_req_valid, 1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("full_refill_outstanding", bus.outstanding, DEPTH);

    // R burst of 4 beats, new request pushed on the last beat
    do_reset();
    do_txn(4'b1000, sel, lat);
    chk("burst_setup_sel", sel, 3);
    for (int b = 0; b < 4; b++) begin
      bus.slv_rsp_valid = 1'b1;
      bus.slv_rsp_last  = (b == 3);
      bus.rsp_ready     = 4'b1000;
      if (b == 2) begin
        bus.req_valid     = 4'b0001;
        bus.slv_req_ready = 1'b1;
      end
      #1;
      chk("burst_rsp_sel", bus.rsp_sel, 3);
      chk("burst_rsp_valid", bus.rsp_valid, 4'b1000);
      chk("burst_slv_rsp_ready", bus.slv_rsp_ready, 1);
      chk("burst_outstanding", bus.outstanding, 1);
      if (b == 3) chk("burst_push_valid", bus.slv_req_valid, 1);
      @(negedge clk);
    end
    idle_inputs();
    #1;
    chk("burst_outstanding_after", bus.outstanding, 1);
    chk("burst_new_head", bus.rsp_sel, 0);

    // Unsolicited response with an empty FIFO is stalled
    do_reset();
    bus.slv_rsp_valid = 1'b1;
    bus.slv_rsp_last  = 1'b1;
    bus.rsp_ready     = 4'b1111;
    #1;
    chk("empty_slv_rsp_ready", bus.slv_rsp_ready, 0);
    chk("empty_rsp_valid", bus.rsp_valid, 0);
    chk("empty_rsp_sel", bus.rsp_sel, 0);
    @(negedge clk);
    #1;
    chk("empty_outstanding", bus.outstanding, 0);
    idle_inputs();

    // Asynchronous reset mid-burst with a grant pending
    do_txn(4'b0010, sel, lat);
    do_txn(4'b0100, sel, lat);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    bus.slv_rsp_valid = 1'b1;
    bus.slv_rsp_last  = 1'b0;
    bus.rsp_ready     = 4'b1111;
    #1;
    chk("midrst_pre_rsp_valid", bus.rsp_valid, 4'b0010);
    chk("midrst_pre_slv_req_valid", bus.slv_req_valid, 1);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    // Randomized run against a queue-based model
    do_reset();
    begin
      int         q [$];
      int         granted;
      int         msel;
      int         mlast;
      logic [3:0] pend;
      logic [3:0] exp_rr;
      logic [3:0] exp_rv;
      logic       exp_srv;
      logic       exp_srr;
      int         exp_rsel;
      bit         full, hs, popv;
      int         p_rsp;

      granted = -1;
      msel    = 0;
      mlast   = 3;
      pend    = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        @(negedge clk);
        for (int m = 0; m < 4; m++)
          if (!pend[m] && $urandom_range(99) < 35) pend[m] = 1'b1;
        p_rsp = (cyc < 500) ? 15 : 55;
        bus.req_valid     = pend;
        bus.slv_req_ready = ($urandom_range(99) < 60);
        bus.slv_rsp_valid = ($urandom_range(99) < p_rsp);
        bus.slv_rsp_last  = 1'($urandom_range(1));
        bus.rsp_ready     = 4'($urandom);
        #1;

        full    = (q.size() == DEPTH);
        exp_srv = 1'b0;
        exp_rr  = '0;
        if (granted >= 0) begin
          exp_srv         = pend[granted] && !full;
          exp_rr[granted] = bus.slv_req_ready && !full;
        end
        exp_rv   = '0;
        exp_srr  = 1'b0;
        exp_rsel = 0;
        if (q.size() > 0) begin
          exp_rsel         = q[0];
          exp_rv[q[0]]     = bus.slv_rsp_valid;
          exp_srr          = bus.rsp_ready[q[0]];
        end

        chk("rnd_slv_req_valid", bus.slv_req_valid, exp_srv);
        chk("rnd_req_ready", bus.req_ready, exp_rr);
        chk("rnd_req_sel", bus.req_sel, msel);
        chk("rnd_rsp_valid", bus.rsp_valid, exp_rv);
        chk("rnd_rsp_sel", bus.rsp_sel, exp_rsel);
        chk("rnd_slv_rsp_ready", bus.slv_rsp_ready, exp_srr);
        chk("rnd_outstanding", bus.outstanding, q.size());

        hs   = (granted >= 0) && exp_srv && bus.slv_req_ready;
        popv = (q.size() > 0) && bus.slv_rsp_valid && exp_srr && bus.slv_rsp_last;
        if (popv) void'(q.pop_front());
        if (hs) begin
          q.push_back(granted);
          mlast         = granted;
          pend[granted] = 1'b0;
          granted       = -1;
        end else if (granted < 0 && pend != 0) begin
          for (int k = 1; k <= 4; k++) begin
            if (pend[(mlast + k) % 4]) begin
              granted = (mlast + k) % 4;
              break;
            end
          end
          msel = granted;
        end
      end
    end

    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
